// File: rtl/nios_core_onchip_mem_loader_if.sv
// Byte-stream and RAM-write-port bundle for nios_core_onchip_mem_loader.
// master: the loader (consumes the stream, drives the RAM write port).
// slave : the environment (drives the stream and the RAM reset_req).
interface nios_core_onchip_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic              mem_reset_req;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;

    modport master (
        input  s_valid, s_data, s_last, mem_reset_req,
        output s_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata
    );

    modport slave (
        output s_valid, s_data, s_last, mem_reset_req,
        input  s_ready, mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata
    );
endinterface

// File: rtl/nios_core_onchip_mem_loader.sv
// nios_core_onchip_mem_loader: packs a byte stream into little-endian 32-bit
// words and writes them into the nios_core on-chip RAM, starting at a word
// address latched on start and wrapping modulo DEPTH.
// Optional feature macro: NIOS_CORE_LOADER_CHECKSUM_EN (32-bit byte sum).
module nios_core_onchip_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    nios_core_onchip_mem_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [ADDR_W:0]      word_count,
    output logic [31:0]          checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   WC_LAST   = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [3:0]        be_q;
    logic [1:0]        idx_q;
    logic              last_q;
    logic [ADDR_W:0]   wc_q;
    logic              ovf_q;

    logic              accept;
    logic              commit;
    logic              take_start;
    logic              s_ready_c;
    logic              write_c;

    // State register; an asynchronous reset aborts any session on the spot.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments on every register so all flops
        // sample pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and handshake/strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and infers a latch.
        state_next = state;
        s_ready_c  = 1'b0;
        write_c    = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        take_start = 1'b0;
        case (state)
            IDLE: begin
                take_start = start;
                if (start) state_next = FILL;
            end
            FILL: begin
                s_ready_c = 1'b1;
                accept    = bus.s_valid;
                if (bus.s_valid && (idx_q == 2'd3 || bus.s_last)) state_next = WRITE;
            end
            WRITE: begin
                write_c = 1'b1;
                commit  = ~bus.mem_reset_req;
                if (!bus.mem_reset_req) begin
                    if (last_q)              state_next = DONE;
                    else if (wc_q == WC_LAST) state_next = DONE;
                    else                      state_next = FILL;
                end
            end
            DONE: begin
                take_start = start;
                if (start) state_next = FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word assembly, address stepping and session status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            be_q   <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            wc_q   <= '0;
            ovf_q  <= 1'b0;
        end else if (take_start) begin
            addr_q <= base_addr;
            data_q <= '0;
            be_q   <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            wc_q   <= '0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            data_q[8*idx_q +: 8] <= bus.s_data;
            be_q[idx_q]          <= 1'b1;
            idx_q                <= idx_q + 2'd1;
            last_q               <= bus.s_last;
        end else if (commit) begin
            addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
            wc_q   <= wc_q + 1'b1;
            data_q <= '0;
            be_q   <= '0;
            idx_q  <= '0;
            if (!last_q && wc_q == WC_LAST) ovf_q <= 1'b1;
        end
    end

`ifdef NIOS_CORE_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    // Running modulo-2^32 sum of the bytes accepted in this session.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           sum_q <= '0;
        else if (take_start) sum_q <= '0;
        else if (accept)     sum_q <= sum_q + {24'd0, bus.s_data};
    end

    assign checksum = sum_q;
`else
    assign checksum = 32'd0;
`endif

    assign bus.s_ready        = s_ready_c;
    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_writedata  = data_q;
    assign bus.mem_chipselect = write_c;
    assign bus.mem_write      = write_c;

    assign busy       = (state == FILL) || (state == WRITE);
    assign done       = (state == DONE);
    assign overflow   = ovf_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_nios_core_onchip_mem_loader.sv
// Directed testbench for nios_core_onchip_mem_loader. Inputs change 1 ns
// after the rising edge; outputs are sampled on the falling edge.
module tb_nios_core_onchip_mem_loader;

    localparam int ADDR_W = 10;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        be;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy, done, overflow;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       checksum;

    int vectors = 0;
    int errors  = 0;
    wr_t wq[$];

    nios_core_onchip_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    nios_core_onchip_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Record every write that the next rising edge will commit.
    always @(negedge clk) begin
        if (bus.mem_write === 1'b1 && bus.mem_reset_req === 1'b0 && reset === 1'b0)
            wq.push_back('{addr: bus.mem_address, data: bus.mem_writedata, be: bus.mem_byteenable});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    // Present one byte and hold it until it is accepted (bounded).
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        forever begin
            @(negedge clk);
            if (bus.s_ready === 1'b1) break;
            n++;
            if (n > 50) begin
                vectors++;
                errors++;
                $display("FAIL send_byte_timeout: byte %h never accepted", d);
                break;
            end
            tick();
        end
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
            if (n > 20) begin
                vectors++;
                errors++;
                $display("FAIL wait_done_timeout: done stayed %b", done);
                break;
            end
        end
        tick();
    endtask

    task automatic chk_write(input string name, input int i, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [3:0] be);
        vectors++;
        if (wq.size() <= i) begin
            errors++;
            $display("FAIL %s: write %0d missing, only %0d seen", name, i, wq.size());
        end else if (wq[i].addr !== a || wq[i].data !== d || wq[i].be !== be) begin
            errors++;
            $display("FAIL %s: got addr %h data %h be %h, expected addr %h data %h be %h",
                     name, wq[i].addr, wq[i].data, wq[i].be, a, d, be);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        vectors++;
        if ({bus.s_ready, bus.mem_address, bus.mem_byteenable, bus.mem_chipselect, bus.mem_write,
             bus.mem_writedata, busy, done, overflow, word_count, checksum} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr %h data %h be %h wr %b busy %b done %b wc %h cks %h, expected all 0",
                     bus.mem_address, bus.mem_writedata, bus.mem_byteenable, bus.mem_write,
                     busy, done, word_count, checksum);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        wq.delete();
        do_start(10'h000);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_done();
        chk_write("basic_w0", 0, 10'h000, 32'h04030201, 4'hF);
        chk_write("basic_w1", 1, 10'h001, 32'h08070605, 4'hF);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || overflow !== 1'b0 || word_count !== 11'd2) begin
            errors++;
            $display("FAIL basic_status: done %b busy %b ovf %b wc %0d, expected 1 0 0 2",
                     done, busy, overflow, word_count);
        end
        vectors++;
`ifdef NIOS_CORE_LOADER_CHECKSUM_EN
        if (checksum !== 32'h00000024) begin
`else
        if (checksum !== 32'h00000000) begin
`endif
            errors++;
            $display("FAIL basic_checksum: got %h", checksum);
        end
        vectors++;
        if (wq.size() != 2) begin
            errors++;
            $display("FAIL basic_write_count: got %0d expected 2", wq.size());
        end
    endtask

    task automatic test_partial_word();
        wq.delete();
        do_start(10'h010);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        do_start(10'h2AA);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        send_byte(8'hEE, 1'b1);
        wait_done();
        chk_write("partial_w0", 0, 10'h010, 32'hDDCCBBAA, 4'hF);
        chk_write("partial_w1", 1, 10'h011, 32'h000000EE, 4'h1);
        vectors++;
        if (word_count !== 11'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL partial_status: wc %0d done %b, expected 2 1", word_count, done);
        end
    endtask

    task automatic test_reset_req_stall();
        int held = 0;
        int moved = 0;
        logic [ADDR_W-1:0] a0;
        logic [31:0] d0;
        wq.delete();
        do_start(10'h020);
        bus.mem_reset_req = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        a0 = bus.mem_address;
        d0 = bus.mem_writedata;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.mem_write === 1'b1) held++;
            if (bus.mem_address !== a0 || bus.mem_writedata !== d0) moved++;
            tick();
        end
        vectors++;
        if (word_count !== 11'd0) begin
            errors++;
            $display("FAIL stall_wc_hold: got %0d expected 0", word_count);
        end
        bus.mem_reset_req = 1'b0;
        @(negedge clk);
        if (bus.mem_write === 1'b1) held++;
        if (bus.mem_address !== a0 || bus.mem_writedata !== d0) moved++;
        tick();
        @(negedge clk);
        vectors++;
        if (held != 4 || moved != 0 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL stall_strobe: held %0d moved %0d wr_after %b, expected 4 0 0",
                     held, moved, bus.mem_write);
        end
        vectors++;
        if (word_count !== 11'd1 || wq.size() != 1) begin
            errors++;
            $display("FAIL stall_count: wc %0d writes %0d, expected 1 1", word_count, wq.size());
        end
        chk_write("stall_w0", 0, 10'h020, 32'h44332211, 4'hF);
        tick();
    endtask

    task automatic test_wrap();
        wq.delete();
        do_start(10'h3FF);
        for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i), i == 7);
        wait_done();
        chk_write("wrap_w0", 0, 10'h3FF, 32'h53525150, 4'hF);
        chk_write("wrap_w1", 1, 10'h000, 32'h57565554, 4'hF);
        vectors++;
        if (done !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_status: done %b ovf %b, expected 1 0", done, overflow);
        end
    endtask

    task automatic test_overflow();
        int bad = 0;
        int rdy = 0;
        wq.delete();
        do_start(10'h000);
        for (int i = 0; i < 4096; i++) send_byte(8'(i), 1'b0);
        wait_done();
        vectors++;
        if (done !== 1'b1 || overflow !== 1'b1 || word_count !== 11'h400 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ovf_status: done %b ovf %b wc %0d busy %b, expected 1 1 1024 0",
                     done, overflow, word_count, busy);
        end
        for (int w = 0; w < wq.size(); w++)
            if (wq[w].addr !== 10'(w) || wq[w].be !== 4'hF) bad++;
        vectors++;
        if (wq.size() != 1024 || bad != 0) begin
            errors++;
            $display("FAIL ovf_writes: %0d writes, %0d bad addresses, expected 1024 0", wq.size(), bad);
        end
        chk_write("ovf_last_word", 1023, 10'h3FF, 32'hFFFEFDFC, 4'hF);
        for (int i = 4096; i < 4100; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(i);
            @(negedge clk);
            if (bus.s_ready !== 1'b0) rdy++;
            tick();
        end
        bus.s_valid = 1'b0;
        vectors++;
        if (rdy != 0 || wq.size() != 1024 || word_count !== 11'h400) begin
            errors++;
            $display("FAIL ovf_extra_bytes: ready seen %0d writes %0d wc %0d, expected 0 1024 1024",
                     rdy, wq.size(), word_count);
        end
    endtask

    task automatic test_reset_mid_fill();
        wq.delete();
        do_start(10'h040);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        reset = 1'b1;
        #2;
        vectors++;
        if ({bus.s_ready, bus.mem_address, bus.mem_byteenable, bus.mem_write, bus.mem_writedata,
             busy, done, overflow, word_count, checksum} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: addr %h data %h be %h busy %b wc %h cks %h, expected all 0",
                     bus.mem_address, bus.mem_writedata, bus.mem_byteenable, busy, word_count, checksum);
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        vectors++;
        if (wq.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_write: writes %0d busy %b, expected 0 0", wq.size(), busy);
        end
    endtask

    initial begin
        bus.s_valid       = 1'b0;
        bus.s_data        = '0;
        bus.s_last        = 1'b0;
        bus.mem_reset_req = 1'b0;
        test_reset();
        test_basic();
        test_partial_word();
        test_reset_req_stall();
        test_wrap();
        test_overflow();
        test_reset_mid_fill();
        test_basic();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
